// File: rtl/mb_rx_flit_assembler.sv
// Mainband receive flit assembler: checks valid-lane framing, deserialises 8-UI byte groups
// into FLIT_BYTES-byte flits (optional lane reversal) and buffers them in a small flit FIFO.
module mb_rx_flit_assembler #(
  parameter int NUM_LANES      = 16,
  parameter int FLIT_BYTES     = 64,
  parameter int FLIT_BUF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ui_en_i,
  input  logic                              valid_i,
  input  logic [NUM_LANES-1:0]              data_i,
  input  logic                              lane_rev_i,
  output logic                              flit_valid_o,
  input  logic                              flit_ready_i,
  output logic [FLIT_BYTES*8-1:0]           flit_data_o,
  output logic                              frame_err_o,
  output logic                              overflow_o,
  output logic [7:0]                        drop_cnt_o,
  output logic [$clog2(FLIT_BUF_DEPTH):0]   level_o
);
  localparam int GROUPS = FLIT_BYTES / NUM_LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PW     = $clog2(FLIT_BUF_DEPTH);
  localparam int LW     = PW + 1;
  localparam int FW     = FLIT_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      ui_q, ui_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic            rev_q, rev_d;
  logic [FW-1:0]   part_q, part_d;
  logic            push_q, push_d;
  logic            ferr_q, ferr_d;

  logic [FW-1:0]   mem_q [FLIT_BUF_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   cnt_q;
  logic            ovf_q;
  logic [7:0]      drop_q;
  logic            pop_s, full_s, wr_s, drop_s;

  // Scatter one UI's lane bits into their flit byte positions (bit ui of each byte).
  function automatic logic [FW-1:0] put_bits(input logic [FW-1:0] f, input logic [NUM_LANES-1:0] d,
                                             input int grp, input int ui, input logic rev);
    logic [FW-1:0] r;
    int lb;
    r = f;
    for (int l = 0; l < NUM_LANES; l++) begin
      lb = rev ? (NUM_LANES - 1 - l) : l;
      r[(grp * NUM_LANES + lb) * 8 + ui] = d[l];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ui_q    <= 3'd0;
      grp_q   <= '0;
      rev_q   <= 1'b0;
      part_q  <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ui_q    <= ui_d;
      grp_q   <= grp_d;
      rev_q   <= rev_d;
      part_q  <= part_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ui_d    = ui_q;
    grp_d   = grp_q;
    rev_d   = rev_q;
    part_d  = part_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ui_en_i && valid_i) begin
          rev_d   = lane_rev_i;
          part_d  = put_bits(part_q, data_i, 0, 0, lane_rev_i);
          ui_d    = 3'd1;
          grp_d   = '0;
          state_d = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        // UI0..3 must carry valid=1, UI4..7 valid=0; anything else abandons the flit.
        if (!ui_en_i) begin
          state_d = ST_RECV;
        end else if (valid_i != (ui_q < 3'd4)) begin
          ferr_d  = 1'b1;
          state_d = ST_RESYNC;
        end else begin
          part_d = put_bits(part_q, data_i, int'(grp_q), int'(ui_q), rev_q);
          ui_d   = ui_q + 3'd1;
          if (ui_q == 3'd7) begin
            if (grp_q == GW'(GROUPS - 1)) begin
              push_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              grp_d = grp_q + GW'(1);
            end
          end else begin
            grp_d = grp_q;
          end
        end
      end
      ST_RESYNC: begin
        if (ui_en_i && !valid_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESYNC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop_s  = (cnt_q != '0) && flit_ready_i;
  assign full_s = (cnt_q == LW'(FLIT_BUF_DEPTH));
  assign wr_s   = push_q && (!full_s || pop_s);
  assign drop_s = push_q && full_s && !pop_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FLIT_BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      ovf_q <= drop_s;
      if (wr_s) begin
        mem_q[wr_ptr_q] <= part_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_s, pop_s})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop_s && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign flit_valid_o = (cnt_q != '0);
  assign flit_data_o  = mem_q[rd_ptr_q];
  assign level_o      = cnt_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_mb_rx_flit_assembler.sv
// Scoreboard bench for mb_rx_flit_assembler: expected flits are queued at stimulus time and a
// negedge monitor compares every handshaked flit; pulse counters track frame/overflow events.
module tb_mb_rx_flit_assembler;
  localparam int NL = 16;
  localparam int FB = 64;
  localparam int FW = FB * 8;

  logic          clk = 1'b0;
  logic          reset, ui_en_i, valid_i, lane_rev_i, flit_ready_i;
  logic [NL-1:0] data_i;
  logic          flit_valid_o, frame_err_o, overflow_o;
  logic [FW-1:0] flit_data_o;
  logic [7:0]    drop_cnt_o;
  logic [2:0]    level_o;

  int            checks = 0, errors = 0;
  int            fe_cnt = 0, ov_cnt = 0;
  bit            gap_mode = 1'b0;
  logic [FW-1:0] exp_q[$];

  mb_rx_flit_assembler #(.NUM_LANES(NL), .FLIT_BYTES(FB), .FLIT_BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ui_en_i(ui_en_i), .valid_i(valid_i), .data_i(data_i),
    .lane_rev_i(lane_rev_i), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i),
    .flit_data_o(flit_data_o), .frame_err_o(frame_err_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_w(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard compare on each accepted flit.
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (frame_err_o) fe_cnt++;
    if (overflow_o) ov_cnt++;
    if (flit_valid_o && flit_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %0h expected none", flit_data_o);
      end else begin
        e = exp_q.pop_front();
        chk_w("flit_data", flit_data_o, e);
      end
    end
  end

  function automatic logic [FW-1:0] mk_text();
    string s;
    logic [FW-1:0] r;
    s = "Hello, World! This is a test. Flit 0";
    for (int i = 0; i < FB; i++) r[i*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [FW-1:0] mk_pat(input int seed);
    logic [FW-1:0] r;
    for (int i = 0; i < FB; i++) r[i*8 +: 8] = 8'(seed * 37 + i * 11 + 3);
    return r;
  endfunction

  // Stream byte (g*NL + l) is the byte lane l carries in group g.
  function automatic logic [FW-1:0] exp_flit(input logic [FW-1:0] s, input logic rev);
    logic [FW-1:0] r;
    int lb;
    for (int g = 0; g < FB / NL; g++)
      for (int l = 0; l < NL; l++) begin
        lb = rev ? (NL - 1 - l) : l;
        r[(g*NL + lb)*8 +: 8] = s[(g*NL + l)*8 +: 8];
      end
    return r;
  endfunction

  task automatic ui(input logic v, input logic [NL-1:0] d);
    ui_en_i = 1'b1;
    valid_i = v;
    data_i  = d;
    @(posedge clk); #1;
    ui_en_i = 1'b0;
    if (gap_mode) begin
      valid_i = 1'($urandom);
      data_i  = NL'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_stream(input logic [FW-1:0] s, input logic rev, input int tog_ui,
                             input int err_ui, input int stop_ui);
    logic          v;
    logic [NL-1:0] d;
    lane_rev_i = rev;
    for (int u = 0; u < 32; u++) begin
      if (u == stop_ui) return;
      if (u == tog_ui) lane_rev_i = ~lane_rev_i;
      v = ((u % 8) < 4);
      for (int l = 0; l < NL; l++) d[l] = s[((u / 8) * NL + l) * 8 + (u % 8)];
      if (u == err_ui) begin
        ui(~v, d);
        ui(1'b0, 16'h0000);
        ui(1'b0, 16'h0000);
        return;
      end
      ui(v, d);
    end
  endtask

  task automatic drain();
    int n;
    flit_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || flit_valid_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain_done", int'(n < 300), 1);
    @(posedge clk); #1;
    chk_i("drain_level", int'(level_o), 0);
  endtask

  initial begin
    logic [FW-1:0] hello, sa, sb, sc, sd, sf;
    logic [FW-1:0] fl[5];
    int fe0, ov0;
    reset = 1'b1; ui_en_i = 1'b0; valid_i = 1'b0; data_i = '0;
    lane_rev_i = 1'b0; flit_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_i("rst_valid", int'(flit_valid_o), 0);
    chk_w("rst_data", flit_data_o, '0);
    chk_i("rst_level", int'(level_o), 0);
    chk_i("rst_drop", int'(drop_cnt_o), 0);
    chk_i("rst_pulses", int'({frame_err_o, overflow_o}), 0);
    reset = 1'b0;

    // Single flit: latency and hand-known bytes.
    hello = mk_text();
    flit_ready_i = 1'b1;
    exp_q.push_back(hello);
    send_stream(hello, 1'b0, -1, -1, -1);
    chk_i("lat_edge1_valid", int'(flit_valid_o), 0);
    @(posedge clk); #1;
    chk_i("lat_edge2_valid", int'(flit_valid_o), 1);
    chk_i("byte0", int'(flit_data_o[7:0]), 32'h48);
    chk_i("byte13", int'(flit_data_o[111:104]), 32'h20);
    chk_i("byte63", int'(flit_data_o[511:504]), 32'h20);
    drain();

    // Gapped UIs with garbage in the gaps.
    fe0 = fe_cnt;
    gap_mode = 1'b1;
    exp_q.push_back(hello);
    send_stream(hello, 1'b0, -1, -1, -1);
    gap_mode = 1'b0;
    drain();
    chk_i("gap_no_ferr", fe_cnt - fe0, 0);

    // Lane reversal latched at flit start; mid-flit toggle ignored.
    sa = mk_pat(1);
    sa[7:0] = 8'hA5;
    flit_ready_i = 1'b0;
    exp_q.push_back(exp_flit(sa, 1'b1));
    send_stream(sa, 1'b1, 12, -1, -1);
    @(posedge clk); #1;
    chk_i("rev_byte15", int'(flit_data_o[127:120]), 32'hA5);
    sb = mk_pat(2);
    exp_q.push_back(exp_flit(sb, lane_rev_i));
    send_stream(sb, lane_rev_i, -1, -1, -1);
    drain();

    // Framing error at UI5 of group 1, then a good flit.
    fe0 = fe_cnt;
    sc = mk_pat(3);
    send_stream(sc, 1'b0, -1, 13, -1);
    repeat (3) ui(1'b0, 16'h0000);
    chk_i("ferr_pulse", fe_cnt - fe0, 1);
    chk_i("ferr_no_push", int'(level_o), 0);
    sd = mk_pat(4);
    flit_ready_i = 1'b1;
    exp_q.push_back(sd);
    send_stream(sd, 1'b0, -1, -1, -1);
    drain();

    // Overflow: five back-to-back flits, no consumer.
    ov0 = ov_cnt;
    flit_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fl[k] = mk_pat(10 + k);
      if (k < 4) exp_q.push_back(fl[k]);
    end
    for (int k = 0; k < 5; k++) send_stream(fl[k], 1'b0, -1, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk_i("ovf_level", int'(level_o), 4);
    chk_i("ovf_pulse", ov_cnt - ov0, 1);
    chk_i("ovf_drop_cnt", int'(drop_cnt_o), 1);
    chk_w("hold_head", flit_data_o, fl[0]);
    drain();

    // Reset after 10 UIs discards the partial flit.
    sf = mk_pat(20);
    send_stream(sf, 1'b0, -1, -1, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_i("mrst_valid", int'(flit_valid_o), 0);
    chk_w("mrst_data", flit_data_o, '0);
    chk_i("mrst_level", int'(level_o), 0);
    chk_i("mrst_drop", int'(drop_cnt_o), 0);
    reset = 1'b0;
    exp_q.push_back(sf);
    send_stream(sf, 1'b0, -1, -1, -1);
    drain();

    // Full FIFO: pop and push on the same edge.
    ov0 = ov_cnt;
    flit_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fl[k] = mk_pat(30 + k);
      exp_q.push_back(fl[k]);
    end
    for (int k = 0; k < 4; k++) send_stream(fl[k], 1'b0, -1, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    chk_i("full_level", int'(level_o), 4);
    send_stream(fl[4], 1'b0, -1, -1, -1);
    flit_ready_i = 1'b1;
    @(posedge clk); #1;
    flit_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_i("pp_level", int'(level_o), 4);
    chk_i("pp_drop", int'(drop_cnt_o), 0);
    chk_i("pp_no_ovf", ov_cnt - ov0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
